// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter with bounded lock for the shared memory-mapped I/O bus.
// Each accepted transaction runs IDLE -> ISSUE -> RESP; read data is returned to the winner.
module io_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  logic [NUM_REQ*8-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   busy,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [7:0]             io_addr,
  output logic [7:0]             io_wdata,
  input  logic [7:0]             io_rdata
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant, last_grant_d;
  logic            lock_hold, lock_hold_d;
  logic [CW-1:0]   lock_cnt, lock_cnt_d;

  logic            mem_read_d, mem_write_d;
  logic [7:0]      io_addr_d, io_wdata_d;
  logic [NUM_REQ-1:0] rsp_valid_d;
  logic [7:0]      rsp_rdata_d;
  logic            busy_d;
  logic [NUM_REQ-1:0] ready_c;

  logic [GW-1:0]   rr_idx, win_idx;
  logic            rr_found, lock_ok;
  int unsigned     cand;

  logic [7:0]      addr_arr  [NUM_REQ];
  logic [7:0]      wdata_arr [NUM_REQ];

  // Split the flat request buses into per-requester bytes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*8 +: 8];
    assign wdata_arr[g] = req_wdata[g*8 +: 8];
  end

  // Winner selection: circular search from last_grant+1, overridden by a live lock.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_grant) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && req_valid[GW'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = GW'(cand);
      end
    end
    lock_ok = lock_hold && req_valid[last_grant] && (lock_cnt < CW'(LOCK_MAX));
    win_idx = lock_ok ? last_grant : rr_idx;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant;
    lock_hold_d  = lock_hold;
    lock_cnt_d   = lock_cnt;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    io_addr_d    = 8'h00;
    io_wdata_d   = 8'h00;
    rsp_valid_d  = '0;
    rsp_rdata_d  = 8'h00;
    ready_c      = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d          = ISSUE;
          grant_d          = win_idx;
          ready_c[win_idx] = 1'b1;
          mem_write_d      = req_write[win_idx];
          mem_read_d       = !req_write[win_idx];
          io_addr_d        = addr_arr[win_idx];
          io_wdata_d       = wdata_arr[win_idx];
          lock_hold_d      = req_lock[win_idx];
          lock_cnt_d       = (lock_ok && req_lock[win_idx]) ? lock_cnt + CW'(1) : '0;
        end
      end
      ISSUE: begin
        state_d              = RESP;
        rsp_valid_d[grant_q] = 1'b1;
        rsp_rdata_d          = mem_read ? io_rdata : 8'h00;
      end
      RESP: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, arbitration history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_grant <= LAST_IDX;
      lock_hold  <= 1'b0;
      lock_cnt   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      io_addr    <= 8'h00;
      io_wdata   <= 8'h00;
      rsp_valid  <= '0;
      rsp_rdata  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_grant <= last_grant_d;
      lock_hold  <= lock_hold_d;
      lock_cnt   <= lock_cnt_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      io_addr    <= io_addr_d;
      io_wdata   <= io_wdata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      busy       <= busy_d;
    end
  end

  // Accept strobe is a same-cycle decision; held low while reset is asserted.
  assign req_ready = ready_c & {NUM_REQ{rst_n}};

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: grant-order vectors plus directed reset/pulse sequences,
// with a scoreboard tracking bus strobes, responses and read data.
module tb_io_bus_arbiter;

  localparam int unsigned NR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_write, req_lock, req_ready, rsp_valid;
  logic [NR*8-1:0] req_addr, req_wdata;
  logic [7:0]      rsp_rdata, io_addr, io_wdata, io_rdata;
  logic            busy, mem_read, mem_write;

  io_bus_arbiter #(.NUM_REQ(NR), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  // I/O register model: switches, LED (writable), temperature; unmapped reads return EE.
  logic [7:0] sw_reg   = 8'h5A;
  logic [7:0] led_reg  = 8'h00;
  logic [7:0] temp_reg = 8'h33;

  function automatic logic [7:0] io_model(input logic [7:0] a);
    case (a)
      8'hF0:   return sw_reg;
      8'hF1:   return led_reg;
      8'hF2:   return temp_reg;
      default: return 8'hEE;
    endcase
  endfunction

  always_comb begin
    io_rdata = 8'h00;
    if (mem_read) begin
      case (io_addr)
        8'hF0:   io_rdata = sw_reg;
        8'hF1:   io_rdata = led_reg;
        8'hF2:   io_rdata = temp_reg;
        default: io_rdata = 8'hEE;
      endcase
    end
  end

  always @(posedge clk) if (mem_write && io_addr == 8'hF1) led_reg <= io_wdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard of expected responses, pushed at accept and popped at rsp_valid.
  typedef struct { int idx; logic [7:0] rdata; int stamp; } sb_t;
  sb_t sbq[$];
  int  grant_log[$];
  int  ready_cyc[$];
  int  cyc = 0;
  logic st1 = 1'b0, st2 = 1'b0;
  logic st1_w;
  logic [7:0] st1_a, st1_d;
  logic [NR-1:0] mon_exp_rv;
  int  mon_idx;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs",
          {req_ready, rsp_valid, rsp_rdata, busy, mem_read, mem_write, io_addr, io_wdata}, '0);
      sbq.delete();
      st1 = 1'b0;
      st2 = 1'b0;
    end else begin
      chk("busy", busy, st1 | st2);
      if (st1) begin
        if (st1_w) chk("bus_write", {mem_read, mem_write, io_addr, io_wdata}, {1'b0, 1'b1, st1_a, st1_d});
        else       chk("bus_read",  {mem_read, mem_write, io_addr}, {1'b1, 1'b0, st1_a});
      end else begin
        chk("bus_idle", {mem_read, mem_write, io_addr, io_wdata}, '0);
      end
      while (sbq.size() > 0 && sbq[0].stamp + 2 < cyc) void'(sbq.pop_front());
      mon_exp_rv = '0;
      if (sbq.size() > 0 && sbq[0].stamp + 2 == cyc) mon_exp_rv[sbq[0].idx] = 1'b1;
      chk("rsp_valid", rsp_valid, mon_exp_rv);
      if (mon_exp_rv != '0) begin
        chk("rsp_rdata", rsp_rdata, sbq[0].rdata);
        void'(sbq.pop_front());
      end
      st2 = st1;
      st1 = 1'b0;
      if (req_ready != '0) begin
        chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        mon_idx = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) mon_idx = i;
        st1   = 1'b1;
        st1_w = req_write[mon_idx];
        st1_a = req_addr[mon_idx*8 +: 8];
        st1_d = req_wdata[mon_idx*8 +: 8];
        grant_log.push_back(mon_idx);
        ready_cyc.push_back(cyc);
        sbq.push_back('{mon_idx, st1_w ? 8'h00 : io_model(st1_a), cyc});
      end
    end
  end

  // Grant-order vectors; ord holds one grant index per nibble, first grant in nibble 0.
  typedef struct {
    logic [NR-1:0]   valid;
    logic [NR-1:0]   write;
    logic [NR-1:0]   lock;
    logic [NR*8-1:0] addr;
    logic [NR*8-1:0] wdata;
    int              n;
    logic [31:0]     ord;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];
  int   rel_cyc;

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    ready_cyc.delete();
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_grants(input int n, input int maxc, input string nm);
    int t;
    t = 0;
    while (grant_log.size() < n && t < maxc) begin
      @(posedge clk); #1;
      t++;
    end
    chk(nm, 64'(grant_log.size()), 64'(n));
  endtask

  initial begin
    logic [31:0] o;
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;

    vecs[0] = '{3'b101, 3'b000, 3'b000, 24'hF2F1F0, 24'h000000, 2, 32'h00000020};
    vecs[1] = '{3'b111, 3'b010, 3'b000, 24'hF2F1F0, 24'h003C00, 6, 32'h00210210};
    vecs[2] = '{3'b010, 3'b010, 3'b000, 24'hF2F1F0, 24'h00A500, 1, 32'h00000001};
    vecs[3] = '{3'b011, 3'b000, 3'b001, 24'hF2F1F0, 24'h000000, 7, 32'h00100000};
    vecs[4] = '{3'b001, 3'b000, 3'b001, 24'hF2F1F0, 24'h000000, 7, 32'h00000000};
    vecs[5] = '{3'b110, 3'b000, 3'b000, 24'hF2F1F0, 24'h000000, 4, 32'h00002121};
    vecs[6] = '{3'b101, 3'b000, 3'b100, 24'hF2F1F0, 24'h000000, 7, 32'h00222220};
    vecs[7] = '{3'b001, 3'b000, 3'b000, 24'hF2F1F1, 24'h000000, 1, 32'h00000000};
    vecs[8] = '{3'b100, 3'b000, 3'b000, 24'h10F1F0, 24'h000000, 1, 32'h00000002};

    for (int v = 0; v < NV; v++) begin
      apply_reset();
      req_valid = vecs[v].valid;
      req_write = vecs[v].write;
      req_lock  = vecs[v].lock;
      req_addr  = vecs[v].addr;
      req_wdata = vecs[v].wdata;
      wait_grants(vecs[v].n, 40 * vecs[v].n, $sformatf("vec%0d_grant_count", v));
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
      o = vecs[v].ord;
      for (int k = 0; k < vecs[v].n && k < grant_log.size(); k++) begin
        chk($sformatf("vec%0d_grant%0d", v, k), 64'(grant_log[k]), 64'(o[4*k +: 4]));
        if (k > 0) chk($sformatf("vec%0d_gap%0d", v, k), 64'(ready_cyc[k] - ready_cyc[k-1]), 64'd3);
      end
      if (ready_cyc.size() > 0)
        chk($sformatf("vec%0d_first_latency", v), 64'(ready_cyc[0] - rel_cyc), 64'd1);
      chk($sformatf("vec%0d_sb_drained", v), 64'(sbq.size()), 64'd0);
      if (v == 2) chk("led_after_write", led_reg, 8'hA5);
    end

    // Reset during ISSUE of a read aborts it; requester 0 regains first priority.
    apply_reset();
    req_addr  = 24'hF2F1F0;
    req_valid = 3'b001;
    wait_grants(1, 20, "abort_first_grant");
    req_valid = 3'b010;
    wait_grants(2, 20, "abort_second_grant");
    #1;
    chk("abort_in_issue", {mem_read, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("abort_async_zero",
        {req_ready, rsp_valid, rsp_rdata, busy, mem_read, mem_write, io_addr, io_wdata}, '0);
    req_valid = 3'b011;
    repeat (2) @(posedge clk);
    #1;
    grant_log.delete();
    ready_cyc.delete();
    rst_n = 1'b1;
    wait_grants(1, 10, "post_abort_grant_count");
    req_valid = '0;
    if (grant_log.size() > 0) chk("post_abort_priority", 64'(grant_log[0]), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("post_abort_sb_drained", 64'(sbq.size()), 64'd0);

    // A one-cycle request during RESP is never granted.
    apply_reset();
    req_addr  = 24'hF2F1F0;
    req_valid = 3'b001;
    wait_grants(1, 10, "pulse_first_grant");
    req_valid = '0;
    @(posedge clk); #1;
    chk("pulse_in_resp", {busy, mem_read, mem_write}, 3'b100);
    req_valid = 3'b010;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("pulse_no_grant", 64'(grant_log.size()), 64'd1);
    chk("pulse_idle", {busy, mem_read, mem_write, req_ready}, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
